// File: rtl/lanectrl_dly_sequencer_if.sv
// Request handshake and per-lane delay-line strobes between training logic and lane controllers.
// Latency: none, this file holds only wiring.
// Backpressure: REQ_VALID/REQ_READY handshake; a request transfers on an edge where both are high.
interface lanectrl_dly_sequencer_if #(
    parameter int NUM_LANES = 4,
    parameter int TAP_W     = 8,
    parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
);
    logic                       REQ_VALID;
    logic                       REQ_READY;
    logic [LANE_W-1:0]          REQ_LANE;
    logic [1:0]                 REQ_OP;
    logic [TAP_W-1:0]           REQ_STEPS;
    logic                       DONE;
    logic                       DONE_ERR;
    logic                       HS_IO_CLK_PAUSE;
    logic [NUM_LANES-1:0]       DELAY_LINE_SEL;
    logic [NUM_LANES-1:0]       DELAY_LINE_LOAD;
    logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION;
    logic [NUM_LANES-1:0]       DELAY_LINE_MOVE;
    logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE;
    logic [NUM_LANES*TAP_W-1:0] TAP_VALUE;

    // Training engine / lane-controller side
    modport master (
        output REQ_VALID, REQ_LANE, REQ_OP, REQ_STEPS, DELAY_LINE_OUT_OF_RANGE,
        input  REQ_READY, DONE, DONE_ERR, HS_IO_CLK_PAUSE, DELAY_LINE_SEL,
               DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE, TAP_VALUE
    );

    // Sequencer side
    modport slave (
        input  REQ_VALID, REQ_LANE, REQ_OP, REQ_STEPS, DELAY_LINE_OUT_OF_RANGE,
        output REQ_READY, DONE, DONE_ERR, HS_IO_CLK_PAUSE, DELAY_LINE_SEL,
               DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE, TAP_VALUE
    );
endinterface

// File: rtl/lanectrl_dly_sequencer.sv
// Sequences one delay-line tap adjustment at a time, bracketed by a clock-pause window.
// Latency: accept->DONE = 1+PAUSE_PRE+2*steps+PAUSE_POST (load: steps=1; invalid request: 1); all outputs registered.
// Backpressure: REQ_READY high only while idle; next request accepted the cycle after DONE.
module lanectrl_dly_sequencer #(
    parameter int NUM_LANES  = 4,
    parameter int TAP_W      = 8,
    parameter int RESET_TAP  = 1,
    parameter int PAUSE_PRE  = 2,
    parameter int PAUSE_POST = 2
) (
    input logic FAB_CLK,
    input logic RESET,
    lanectrl_dly_sequencer_if.slave bus
);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W  = $clog2(((PAUSE_PRE > PAUSE_POST) ? PAUSE_PRE : PAUSE_POST) + 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_ACT  = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    localparam logic [TAP_W-1:0] TAP_RST  = TAP_W'(RESET_TAP);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(PAUSE_PRE - 1);
    localparam logic [CNT_W-1:0] CNT_POST = CNT_W'(PAUSE_POST - 1);

    // Sequencing state
    logic [2:0]                 state_q, state_nxt;
    logic [CNT_W-1:0]           cnt_q, cnt_nxt;
    logic [TAP_W-1:0]           steps_q, steps_nxt;
    logic                       slot_b_q, slot_b_nxt;
    logic                       err_q, err_nxt;
    logic [LANE_W-1:0]          lane_q, lane_nxt;
    logic [1:0]                 op_q, op_nxt;
    logic [NUM_LANES*TAP_W-1:0] tap_q, tap_nxt;

    // Registered outputs
    logic                 ready_q, done_q, done_err_q, pause_q;
    logic [NUM_LANES-1:0] sel_q, load_q, dir_q, move_q;
    logic                 pause_nxt;
    logic [NUM_LANES-1:0] sel_nxt, load_nxt, dir_nxt, move_nxt;

    // Slot helpers
    logic             start_slot, move_pulse, load_pulse;
    logic [TAP_W-1:0] cur_tap;
    logic             oor_sel;
    logic             at_limit;

    // Shadow tap and out-of-range status of the captured lane
    always_comb begin
        cur_tap = '0;
        oor_sel = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_q == LANE_W'(i)) begin
                cur_tap = tap_q[i*TAP_W +: TAP_W];
                oor_sel = bus.DELAY_LINE_OUT_OF_RANGE[i];
            end
        end
    end

    assign at_limit = (op_q == OP_INC) ? (cur_tap == '1) : (cur_tap == '0);

    // Next-state logic; a new slot is entered from the end of PRE or a clean cycle B
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        steps_nxt  = steps_q;
        slot_b_nxt = slot_b_q;
        err_nxt    = err_q;
        lane_nxt   = lane_q;
        op_nxt     = op_q;
        tap_nxt    = tap_q;
        start_slot = 1'b0;
        move_pulse = 1'b0;
        load_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.REQ_VALID && ready_q) begin
                    lane_nxt  = bus.REQ_LANE;
                    op_nxt    = bus.REQ_OP;
                    steps_nxt = bus.REQ_STEPS;
                    err_nxt   = 1'b0;
                    if ((int'(bus.REQ_LANE) < NUM_LANES) && (bus.REQ_OP != OP_RSV)) begin
                        state_nxt = ST_PRE;
                        cnt_nxt   = CNT_PRE;
                    end else begin
                        state_nxt = ST_FIN;
                        err_nxt   = 1'b1;
                    end
                end
            end
            ST_PRE: begin
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end else if ((op_q != OP_LOAD) && (steps_q == '0)) begin
                    state_nxt = ST_POST;
                    cnt_nxt   = CNT_POST;
                end else begin
                    start_slot = 1'b1;
                end
            end
            ST_ACT: begin
                if (!slot_b_q) begin
                    // A saturated slot already carries the error; it ends here without a pulse
                    if (err_q) begin
                        state_nxt = ST_POST;
                        cnt_nxt   = CNT_POST;
                    end else begin
                        slot_b_nxt = 1'b1;
                    end
                end else if (op_q == OP_LOAD) begin
                    state_nxt = ST_POST;
                    cnt_nxt   = CNT_POST;
                end else if (oor_sel) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_POST;
                    cnt_nxt   = CNT_POST;
                end else begin
                    steps_nxt = steps_q - TAP_W'(1);
                    if (steps_q == TAP_W'(1)) begin
                        state_nxt = ST_POST;
                        cnt_nxt   = CNT_POST;
                    end else begin
                        start_slot = 1'b1;
                    end
                end
            end
            ST_POST: begin
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end else begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
                err_nxt   = 1'b0;
            end
            default: begin
                state_nxt = ST_IDLE;
                err_nxt   = 1'b0;
            end
        endcase

        if (start_slot) begin
            state_nxt  = ST_ACT;
            slot_b_nxt = 1'b0;
            if (op_q == OP_LOAD) begin
                load_pulse = 1'b1;
            end else if (at_limit) begin
                err_nxt = 1'b1;
            end else begin
                move_pulse = 1'b1;
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane_q == LANE_W'(i)) begin
                    if (load_pulse) begin
                        tap_nxt[i*TAP_W +: TAP_W] = TAP_RST;
                    end else if (move_pulse) begin
                        tap_nxt[i*TAP_W +: TAP_W] = (op_q == OP_INC) ? cur_tap + TAP_W'(1)
                                                                     : cur_tap - TAP_W'(1);
                    end
                end
            end
        end
    end

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        sel_nxt   = '0;
        dir_nxt   = '0;
        move_nxt  = '0;
        load_nxt  = '0;
        pause_nxt = (state_nxt == ST_PRE) || (state_nxt == ST_ACT) || (state_nxt == ST_POST);
        for (int i = 0; i < NUM_LANES; i++) begin
            sel_nxt[i]  = pause_nxt && (lane_nxt == LANE_W'(i));
            dir_nxt[i]  = sel_nxt[i] && (op_nxt == OP_INC);
            move_nxt[i] = move_pulse && (lane_q == LANE_W'(i));
            load_nxt[i] = load_pulse && (lane_q == LANE_W'(i));
        end
    end

    // State and output registers
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            steps_q    <= '0;
            slot_b_q   <= 1'b0;
            err_q      <= 1'b0;
            lane_q     <= '0;
            op_q       <= OP_INC;
            tap_q      <= {NUM_LANES{TAP_RST}};
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
            pause_q    <= 1'b0;
            sel_q      <= '0;
            load_q     <= '0;
            dir_q      <= '0;
            move_q     <= '0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            steps_q    <= steps_nxt;
            slot_b_q   <= slot_b_nxt;
            err_q      <= err_nxt;
            lane_q     <= lane_nxt;
            op_q       <= op_nxt;
            tap_q      <= tap_nxt;
            ready_q    <= (state_nxt == ST_IDLE);
            done_q     <= (state_nxt == ST_FIN);
            done_err_q <= (state_nxt == ST_FIN) && err_nxt;
            pause_q    <= pause_nxt;
            sel_q      <= sel_nxt;
            load_q     <= load_nxt;
            dir_q      <= dir_nxt;
            move_q     <= move_nxt;
        end
    end

    assign bus.REQ_READY            = ready_q;
    assign bus.DONE                 = done_q;
    assign bus.DONE_ERR             = done_err_q;
    assign bus.HS_IO_CLK_PAUSE      = pause_q;
    assign bus.DELAY_LINE_SEL       = sel_q;
    assign bus.DELAY_LINE_LOAD      = load_q;
    assign bus.DELAY_LINE_DIRECTION = dir_q;
    assign bus.DELAY_LINE_MOVE      = move_q;
    assign bus.TAP_VALUE            = tap_q;
endmodule
